// File: rtl/modulus_seq.sv
// rtl/modulus_seq.sv - sequential radix-2 restoring divider producing a mod b and a / b
//
// One quotient bit is resolved per clock. An accepted request takes WIDTH
// cycles in RUN, then one DONE cycle in which done pulses and the result
// registers already hold the new values. A zero divisor skips RUN entirely.
//
// Optional feature macro: MODULUS_SIGNED_EN
//   defined   : a, b are two's complement; results follow Verilog '/' and '%'
//   undefined : all operands unsigned, no sign logic
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   start     in   1      request, accepted when not busy
//   a         in   WIDTH  dividend
//   b         in   WIDTH  divisor
//   busy      out  1      high while iterating
//   done      out  1      one-cycle pulse, results valid and updated
//   r         out  WIDTH  remainder, held until next done
//   q         out  WIDTH  quotient, held until next done
//   div_zero  out  1      last accepted op had b == 0

module modulus_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The shifted partial remainder carries one guard bit so the trial
  // subtraction sign is visible even when the divisor uses the full width.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] q_fix;

`ifdef MODULUS_SIGNED_EN
  logic             neg_r;
  logic             neg_q;
`endif

  // DONE counts as idle so a new request can follow each result directly.
  assign accept = start && (state != S_RUN);
  assign b_zero = (b == '0);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

`ifdef MODULUS_SIGNED_EN
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so the iteration needs no special case.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // The dividend is held in quo and shifts into the remainder one bit per
  // cycle while quotient bits fill in from the LSB.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

`ifdef MODULUS_SIGNED_EN
  // The remainder takes the dividend's sign and the quotient is negated on
  // a sign mismatch. For most-negative / -1 the signs match, so q keeps the
  // wrapped magnitude, which equals a.
  assign r_fix = neg_r ? (~rem_step + 1'b1) : rem_step;
  assign q_fix = neg_q ? (~quo_step + 1'b1) : quo_step;
`else
  assign r_fix = rem_step;
  assign q_fix = quo_step;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = b_zero ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      div_zero <= 1'b0;
`ifdef MODULUS_SIGNED_EN
      neg_r    <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else if (accept) begin
      if (b_zero) begin
        // The result is known immediately, so it loads on the edge into DONE.
        r        <= a;
        q        <= '1;
        div_zero <= 1'b1;
      end else begin
        rem      <= '0;
        quo      <= a_mag;
        dvs      <= b_mag;
        cnt      <= CW'(WIDTH - 1);
`ifdef MODULUS_SIGNED_EN
        neg_r    <= a[WIDTH-1];
        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end
    end else if (state == S_RUN) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        // The last step's result goes straight into the output registers,
        // so done lands one cycle after the final RUN cycle.
        r        <= r_fix;
        q        <= q_fix;
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modulus_seq.sv
// tb/tb_modulus_seq.sv - self-checking bench for modulus_seq with a cycle-level result model

module tb_modulus_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic [W-1:0] q;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  modulus_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .r        (r),
    .q        (q),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of one operation straight from the arithmetic rules.
  function automatic void model_calc(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     output logic [W-1:0] mr, output logic [W-1:0] mq,
                                     output logic mdz);
    int ia;
    int ib;
    int tq;
    int tr;
    if (mb == '0) begin
      mr  = ma;
      mq  = '1;
      mdz = 1'b1;
    end else begin
`ifdef MODULUS_SIGNED_EN
      ia = $signed(ma);
      ib = $signed(mb);
`else
      ia = 0;
      ib = 0;
      ia[W-1:0] = ma;
      ib[W-1:0] = mb;
`endif
      tq  = ia / ib;
      tr  = ia % ib;
      mq  = tq[W-1:0];
      mr  = tr[W-1:0];
      mdz = 1'b0;
    end
  endfunction

  // Model timeline: cyc indexes the cycle that begins at each rising edge.
  // An op accepted at edge n is busy for cycles n..n+W-1 and done in n+W
  // (or done in n for a zero divisor).
  int           cyc = 0;
  int           pend_done = -100;
  logic [W-1:0] pend_r, pend_q;
  logic         pend_dz;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] m_q = '0;
  logic         m_dz = 1'b0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend_done = -100;
      m_r  = '0;
      m_q  = '0;
      m_dz = 1'b0;
    end else if (start && (cyc - 1 >= pend_done)) begin
      model_calc(a, b, pend_r, pend_q, pend_dz);
      pend_done = cyc + ((b == '0) ? 0 : W);
    end
    exp_busy = (cyc < pend_done);
    exp_done = (cyc == pend_done);
    if (exp_done) begin
      m_r  = pend_r;
      m_q  = pend_q;
      m_dz = pend_dz;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", int'(busy), int'(exp_busy));
      chk("cyc_done", int'(done), int'(exp_done));
      chk("cyc_r", int'(r), int'(m_r));
      chk("cyc_q", int'(q), int'(m_q));
      chk("cyc_div_zero", int'(div_zero), int'(m_dz));
      if (busy && done) chk("busy_and_done", 1, 0);
    end
  end

  // Called on a falling edge; returns on the falling edge inside the done
  // cycle, so a following call lands start in that done cycle.
  task automatic do_op(input int ta, input int tb_v, input int er, input int eq,
                       input int edz, input int elat);
    int lat;
    a     = ta[W-1:0];
    b     = tb_v[W-1:0];
    start = 1'b1;
    lat   = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 40);
    chk("op_latency", lat, elat);
    chk("op_r", int'(r), er & ((1 << W) - 1));
    chk("op_q", int'(q), eq & ((1 << W) - 1));
    chk("op_div_zero", int'(div_zero), edz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

`ifndef MODULUS_SIGNED_EN
    do_op(9, 2, 1, 4, 0, 5);
    @(negedge clk);
    do_op(9, 3, 0, 3, 0, 5);
    @(negedge clk);
    do_op(9, 4, 1, 2, 0, 5);
    @(negedge clk);
    do_op(15, 7, 1, 2, 0, 5);
    @(negedge clk);
    do_op(8, 5, 3, 1, 0, 5);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_op(i, 3, i % 3, i / 3, 0, 5);
    end
    @(negedge clk);

    do_op(9, 0, 9, 15, 1, 1);
    @(negedge clk);
    do_op(9, 2, 1, 4, 0, 5);
    @(negedge clk);

    do_op(15, 15, 0, 1, 0, 5);
    do_op(15, 1, 0, 15, 0, 5);
    do_op(0, 0, 0, 15, 1, 1);
    do_op(3, 0, 3, 15, 1, 1);
    @(negedge clk);

    a     = 4'd15;
    b     = 4'd7;
    start = 1'b1;
    @(negedge clk);
    a     = 4'd8;
    b     = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_q", int'(q), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done_r", int'(r), 0);
    do_op(8, 5, 3, 1, 0, 5);
`else
    do_op(4'h9, 4'h2, 4'hF, 4'hD, 0, 5);
    @(negedge clk);
    do_op(4'h7, 4'hE, 4'h1, 4'hD, 0, 5);
    @(negedge clk);
    do_op(4'h8, 4'hF, 4'h0, 4'h8, 0, 5);
    do_op(4'h9, 4'h0, 4'h9, 4'hF, 1, 1);
    do_op(4'h9, 4'hE, 4'hF, 4'h3, 0, 5);
    do_op(4'h7, 4'h2, 4'h1, 4'h3, 0, 5);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
